// File: rtl/audio_i2s_transmitter.sv
// ---------------------------------------------------------------------------
// audio_i2s_transmitter
//
// Serialises left/right PCM pairs from a mixer onto a standard I2S link
// (one-bit data delay after the word-select edge, MSB first).  A single-entry
// holding buffer decouples the mixer from the frame timing.  At every frame
// boundary the buffered pair is moved into the shift register.  If the buffer
// is empty at that point, a silent frame is sent instead.
//
// Parameters
//   BCLK_DIV    aclk cycles per audio_bclk half-period (>= 2)
//   DATA_WIDTH  bits per channel sample; one frame is 2*DATA_WIDTH bits
//
// Ports
//   aclk            in   system clock, rising-edge logic only
//   aresetn         in   asynchronous active-low reset
//   sample_left     in   left sample, two's complement
//   sample_right    in   right sample, two's complement
//   sample_valid    in   left/right pair valid
//   sample_ready    out  holding buffer empty (combinational from register)
//   sample_request  out  one-cycle pulse at each frame load
//   underrun        out  one-cycle pulse when a frame load finds no pair
//   audio_bclk      out  I2S bit clock
//   audio_lrclk     out  I2S word select (0 = left, 1 = right)
//   audio_dout      out  I2S serial data
// ---------------------------------------------------------------------------
module audio_i2s_transmitter #(
    parameter int unsigned BCLK_DIV   = 12,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] sample_left,
    input  logic [DATA_WIDTH-1:0] sample_right,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  sample_request,
    output logic                  underrun,
    output logic                  audio_bclk,
    output logic                  audio_lrclk,
    output logic                  audio_dout
);

    localparam int unsigned FRAME_BITS = 2 * DATA_WIDTH;
    localparam int unsigned DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0]      div_q,            div_d;
    logic                  bclk_q,           bclk_d;
    logic [CNT_W-1:0]      bit_cnt_q,        bit_cnt_d;
    logic                  lrclk_q,          lrclk_d;
    logic                  dout_q,           dout_d;
    logic [FRAME_BITS-1:0] shreg_q,          shreg_d;
    logic                  buf_full_q,       buf_full_d;
    logic [DATA_WIDTH-1:0] buf_left_q,       buf_left_d;
    logic [DATA_WIDTH-1:0] buf_right_q,      buf_right_d;
    logic                  sample_request_q, sample_request_d;
    logic                  underrun_q,       underrun_d;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    logic             div_wrap;
    logic             fall_evt;
    logic             frame_load;
    logic             accept;
    logic [CNT_W-1:0] bit_cnt_inc;

    always_comb begin
        div_wrap    = (div_q == DIV_LAST);
        // bclk is about to go 1 -> 0: the only cycle the serialiser advances
        fall_evt    = div_wrap & bclk_q;
        // the falling event on which bit_cnt wraps back to 0
        frame_load  = fall_evt & (bit_cnt_q == CNT_LAST);
        accept      = sample_valid & ~buf_full_q;
        bit_cnt_inc = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
    end

    // -----------------------------------------------------------------------
    // Bit-clock divider: toggles bclk every BCLK_DIV aclk cycles
    // -----------------------------------------------------------------------
    always_comb begin
        div_d  = div_q;
        bclk_d = bclk_q;
        if (div_wrap) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Serialiser: bit counter, word select, data output and shift register
    // -----------------------------------------------------------------------
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        dout_d    = dout_q;
        shreg_d   = shreg_q;
        if (fall_evt) begin
            bit_cnt_d = bit_cnt_inc;
            lrclk_d   = bit_cnt_inc[CNT_W-1];
            // dout takes the old MSB even on a load, so the previous right
            // LSB goes out while the new frame enters the shift register
            dout_d    = shreg_q[FRAME_BITS-1];
            shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
            if (frame_load) begin
                shreg_d = buf_full_q ? {buf_left_q, buf_right_q} : '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Holding buffer and frame-load status pulses
    // -----------------------------------------------------------------------
    always_comb begin
        buf_full_d       = buf_full_q;
        buf_left_d       = buf_left_q;
        buf_right_d      = buf_right_q;
        sample_request_d = frame_load;
        underrun_d       = frame_load & ~buf_full_q;
        // A load only drains a pair that was already registered; a pair
        // accepted in the load cycle stays buffered for the next frame.
        if (frame_load && buf_full_q) begin
            buf_full_d = 1'b0;
        end
        // accept and a draining load are exclusive: accept needs buf_full_q=0
        if (accept) begin
            buf_full_d  = 1'b1;
            buf_left_d  = sample_left;
            buf_right_d = sample_right;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            div_q            <= '0;
            bclk_q           <= 1'b0;
            bit_cnt_q        <= CNT_LAST;
            lrclk_q          <= 1'b1;
            dout_q           <= 1'b0;
            shreg_q          <= '0;
            buf_full_q       <= 1'b0;
            buf_left_q       <= '0;
            buf_right_q      <= '0;
            sample_request_q <= 1'b0;
            underrun_q       <= 1'b0;
        end else begin
            div_q            <= div_d;
            bclk_q           <= bclk_d;
            bit_cnt_q        <= bit_cnt_d;
            lrclk_q          <= lrclk_d;
            dout_q           <= dout_d;
            shreg_q          <= shreg_d;
            buf_full_q       <= buf_full_d;
            buf_left_q       <= buf_left_d;
            buf_right_q      <= buf_right_d;
            sample_request_q <= sample_request_d;
            underrun_q       <= underrun_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign sample_ready   = ~buf_full_q;
    assign sample_request = sample_request_q;
    assign underrun       = underrun_q;
    assign audio_bclk     = bclk_q;
    assign audio_lrclk    = lrclk_q;
    assign audio_dout     = dout_q;

endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// ---------------------------------------------------------------------------
// tb_audio_i2s_transmitter
//
// Bench for audio_i2s_transmitter with default parameters.  The stimulus
// process keeps a reference model that knows only the frame schedule
// (loads every 2*BCLK_DIV*2*DATA_WIDTH cycles, starting at 2*BCLK_DIV) and a
// single-entry buffer.  At each load it queues the frame the link must carry.
// A monitor decodes audio_dout on bclk rises, framing on the lrclk 1->0 edge,
// and pops the queue for each completed frame.
// ---------------------------------------------------------------------------
module tb_audio_i2s_transmitter;

    localparam int unsigned BD         = 12;
    localparam int unsigned DW         = 16;
    localparam int unsigned FB         = 2 * DW;
    localparam int unsigned FRAME      = 2 * BD * FB;
    localparam int unsigned FIRST_LOAD = 2 * BD;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] sample_left;
    logic [DW-1:0] sample_right;
    logic          sample_valid;
    logic          sample_ready;
    logic          sample_request;
    logic          underrun;
    logic          audio_bclk;
    logic          audio_lrclk;
    logic          audio_dout;

    audio_i2s_transmitter #(.BCLK_DIV(BD), .DATA_WIDTH(DW)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .sample_left    (sample_left),
        .sample_right   (sample_right),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .sample_request (sample_request),
        .underrun       (underrun),
        .audio_bclk     (audio_bclk),
        .audio_lrclk    (audio_lrclk),
        .audio_dout     (audio_dout)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [FB-1:0] exp_q[$];

    // reference model state
    int unsigned   cyc = 0;
    bit            m_full = 1'b0;
    logic [DW-1:0] m_l = '0;
    logic [DW-1:0] m_r = '0;
    bit            acc_flag = 1'b0;

    // driven stimulus
    logic          drv_v = 1'b0;
    logic [DW-1:0] drv_l = '0;
    logic [DW-1:0] drv_r = '0;

    assign sample_valid = drv_v;
    assign sample_left  = drv_l;
    assign sample_right = drv_r;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic reset_checks();
        chk1("rst_bclk", audio_bclk, 1'b0);
        chk1("rst_lrclk", audio_lrclk, 1'b1);
        chk1("rst_dout", audio_dout, 1'b0);
        chk1("rst_request", sample_request, 1'b0);
        chk1("rst_underrun", underrun, 1'b0);
        chk1("rst_ready", sample_ready, 1'b1);
    endtask

    function automatic bit is_load(input int unsigned c);
        return (c >= FIRST_LOAD) && (((c - FIRST_LOAD) % FRAME) == 0);
    endfunction

    // one aclk edge: advance the model, then check the control outputs
    task automatic step();
        bit ld;
        bit exp_und;
        @(posedge aclk);
        #1;
        cyc++;
        ld       = is_load(cyc);
        exp_und  = ld && !m_full;
        acc_flag = drv_v && !m_full;
        if (ld) begin
            exp_q.push_back(m_full ? {m_l, m_r} : '0);
            m_full = 1'b0;
        end
        if (acc_flag) begin
            m_l    = drv_l;
            m_r    = drv_r;
            m_full = 1'b1;
        end
        chk1("sample_request", sample_request, ld);
        chk1("underrun", underrun, exp_und);
        chk1("sample_ready", sample_ready, !m_full);
        chk1("audio_bclk", audio_bclk, 1'((cyc / BD) % 2));
        if (ld) chk1("lrclk_at_load", audio_lrclk, 1'b0);
    endtask

    task automatic offer_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bit done;
        done  = 1'b0;
        drv_v = 1'b1;
        drv_l = l;
        drv_r = r;
        for (int i = 0; i < 3 * FRAME && !done; i++) begin
            step();
            done = acc_flag;
        end
        drv_v = 1'b0;
        chk1("pair_accepted", done, 1'b1);
    endtask

    // steps at least once, stopping on the cycle just before a frame load
    task automatic skip_to_pre_load();
        step();
        for (int i = 0; i < 2 * FRAME && !is_load(cyc + 1); i++) step();
    endtask

    task automatic random_step();
        step();
        if (acc_flag) begin
            drv_v = ($urandom_range(0, 3) != 0);
            drv_l = DW'($urandom);
            drv_r = DW'($urandom);
        end else if (!drv_v) begin
            if ($urandom_range(0, 999) == 0) drv_v = 1'b1;
        end else if (m_full) begin
            // data changing while blocked must never reach the link
            drv_l = DW'($urandom);
            drv_r = DW'($urandom);
        end
    endtask

    task automatic release_reset();
        exp_q.delete();
        m_full = 1'b0;
        cyc    = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Monitor: decode one frame per lrclk 1->0 boundary and score it
    // -----------------------------------------------------------------------
    bit            prev_bclk = 1'b0;
    bit            prev_lr = 1'b1;
    bit            collecting = 1'b0;
    int            nbits = 0;
    int            hi_cnt = 0;
    logic [FB-1:0] sh = '0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_bclk  = 1'b0;
            prev_lr    = 1'b1;
            collecting = 1'b0;
            nbits      = 0;
            hi_cnt     = 0;
            sh         = '0;
        end else begin
            if (audio_bclk && !prev_bclk) begin
                if (prev_lr && !audio_lrclk) begin
                    if (collecting) begin
                        chkw("bits_per_frame", 32'(nbits), 32'(FB - 1));
                        chkw("lrclk_high_bits", 32'(hi_cnt), 32'(DW));
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL frame_queue: got frame %h expected none queued", {sh[FB-2:0], audio_dout});
                        end else begin
                            chkw("frame_data", {sh[FB-2:0], audio_dout}, exp_q.pop_front());
                        end
                    end
                    collecting = 1'b1;
                    sh         = '0;
                    nbits      = 0;
                    hi_cnt     = 0;
                end else if (collecting) begin
                    sh = {sh[FB-2:0], audio_dout};
                    nbits++;
                    if (audio_lrclk) hi_cnt++;
                end
                prev_lr = audio_lrclk;
            end
            prev_bclk = audio_bclk;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        // reset state, with a pair already offered at release
        drv_v = 1'b1;
        drv_l = 16'hA5C3;
        drv_r = 16'h0F0F;
        repeat (2) @(posedge aclk);
        #1;
        reset_checks();
        @(negedge aclk);
        aresetn = 1'b1;
        step();
        chk1("first_accept", acc_flag, 1'b1);
        drv_v = 1'b0;

        // three back-to-back pairs
        offer_pair(16'h8000, 16'h7FFF);
        offer_pair(16'hFFFF, 16'h0001);
        offer_pair(16'h1234, 16'h5678);

        // one frame without data, then a pair offered in the load cycle itself
        skip_to_pre_load();
        skip_to_pre_load();
        skip_to_pre_load();
        drv_v = 1'b1;
        drv_l = 16'hCAFE;
        drv_r = 16'hBEEF;
        step();
        chk1("load_cycle_accept", acc_flag, 1'b1);
        drv_v = 1'b0;

        // second pair offered while the buffer is full must be ignored
        offer_pair(16'h1357, 16'h2468);
        drv_v = 1'b1;
        drv_l = 16'hDEAD;
        drv_r = 16'hF00D;
        repeat (300) step();
        drv_v = 1'b0;

        // randomized traffic with gaps
        for (int i = 0; i < 16 * FRAME; i++) random_step();

        // reset at bit_cnt = 9
        for (int i = 0; i < 2 * FRAME && !(cyc >= FIRST_LOAD &&
             ((cyc - FIRST_LOAD) % FRAME) == 9 * 2 * BD + 5); i++) random_step();
        aresetn = 1'b0;
        #1;
        reset_checks();
        release_reset();
        for (int i = 0; i < int'(FIRST_LOAD) - 1; i++) step();
        chk1("lrclk_before_first_fall", audio_lrclk, 1'b1);
        step();
        chk1("underrun_after_reset", underrun, 1'b1);

        for (int i = 0; i < 4 * FRAME; i++) random_step();
        drv_v = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
